// File: rtl/edp_mul_seq.sv
// edp_mul_seq: radix-2 Booth multiply step sequencer for the EDP slices; define EDP_MUL_STATS_EN to add a completed-multiply counter
module edp_mul_seq #(
  parameter int MAX_STEPS = 36
) (
  input  logic        clk_edp_h,
  input  logic        clk_mr_reset_h,
  input  logic        mul_start_h,
  input  logic [5:0]  mul_steps_h,
  input  logic        mul_abort_h,
  input  logic        edp_hold_h,
  input  logic        mq_35_h,
`ifdef EDP_MUL_STATS_EN
  output logic [15:0] mul_count_h,
`endif
  output logic        mul_busy_h,
  output logic        mul_done_h,
  output logic        ar_clr_h,
  output logic        mq_load_h,
  output logic [1:0]  ad_func_h,
  output logic        arx_shift_h,
  output logic        mq_shift_h,
  output logic [5:0]  step_count_h
);
  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;
  localparam logic [5:0] MAX_N = 6'(MAX_STEPS);
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d, steps_clamped;
  logic       prev_q, prev_d, run;
  assign run = !edp_hold_h;
  assign steps_clamped = (mul_steps_h == 6'd0 || mul_steps_h > MAX_N) ? MAX_N : mul_steps_h;
  // state, remaining-step count and previously examined multiplier bit
  always_ff @(posedge clk_edp_h) begin
    if (clk_mr_reset_h) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end
  // next state: abort beats hold, hold freezes everything, start only counts in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    if (state_q == IDLE) begin
      if (mul_start_h) begin
        state_d = INIT;
        cnt_d   = steps_clamped;
        prev_d  = 1'b0;
      end
    end else if (mul_abort_h) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (run) begin
      case (state_q)
        INIT: state_d = STEP;
        STEP: begin
          prev_d  = mq_35_h;
          cnt_d   = cnt_q - 6'd1;
          state_d = (cnt_q == 6'd1) ? DONE : STEP;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // control decode from registered state; hold masks every strobe, AD follows Booth pair {mq_35, prev}
  always_comb begin
    mul_busy_h   = state_q != IDLE;
    ar_clr_h     = state_q == INIT && run;
    mq_load_h    = state_q == INIT && run;
    arx_shift_h  = state_q == STEP && run;
    mq_shift_h   = state_q == STEP && run;
    mul_done_h   = state_q == DONE && run;
    ad_func_h    = arx_shift_h ? {mq_35_h & ~prev_q, ~mq_35_h & prev_q} : 2'b00;
    step_count_h = cnt_q;
  end
`ifdef EDP_MUL_STATS_EN
  logic [15:0] mul_count_q;
  assign mul_count_h = mul_count_q;
  // saturating count of done pulses
  always_ff @(posedge clk_edp_h) begin
    if (clk_mr_reset_h) mul_count_q <= '0;
    else if (mul_done_h && mul_count_q != 16'hFFFF) mul_count_q <= mul_count_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_edp_mul_seq.sv
// tb_edp_mul_seq: scoreboard bench for the EDP multiply step sequencer
module tb_edp_mul_seq;
  logic       clk_edp_h = 0, clk_mr_reset_h = 1, mul_start_h = 0, mul_abort_h = 0, edp_hold_h = 0, mq_35_h = 0;
  logic [5:0] mul_steps_h = 0;
  logic       mul_busy_h, mul_done_h, ar_clr_h, mq_load_h, arx_shift_h, mq_shift_h;
  logic [1:0] ad_func_h;
  logic [5:0] step_count_h;
`ifdef EDP_MUL_STATS_EN
  logic [15:0] mul_count_h;
`endif
  int n_cmp = 0, n_bad = 0;
  int busy_cycles, done_cnt, hold_cycles;
  bit init_seen, timed_out;
  logic [6:0] hold_ctrl;
  logic [5:0] end_cnt;
  logic [5:0] exp_cnt[$], obs_cnt[$], obs_hold[$];
  logic [1:0] exp_ad[$], obs_ad[$];

  edp_mul_seq #(.MAX_STEPS(36)) dut (
    .clk_edp_h(clk_edp_h), .clk_mr_reset_h(clk_mr_reset_h), .mul_start_h(mul_start_h),
    .mul_steps_h(mul_steps_h), .mul_abort_h(mul_abort_h), .edp_hold_h(edp_hold_h), .mq_35_h(mq_35_h),
`ifdef EDP_MUL_STATS_EN
    .mul_count_h(mul_count_h),
`endif
    .mul_busy_h(mul_busy_h), .mul_done_h(mul_done_h), .ar_clr_h(ar_clr_h), .mq_load_h(mq_load_h),
    .ad_func_h(ad_func_h), .arx_shift_h(arx_shift_h), .mq_shift_h(mq_shift_h), .step_count_h(step_count_h)
  );

  always #5 clk_edp_h = ~clk_edp_h;

  // Drives one operation (inputs change on negedge, outputs sampled 1ns later) and records what the DUT did.
  // Cycle 0 is the INIT cycle; hold/abort windows are given in those cycle numbers.
  task automatic run_op(input logic [5:0] steps, input logic [63:0] mq_seq, input int hold_at, input int hold_len,
                        input int abort_at, input bit start_in_done);
    int k;
    k = 0;
    busy_cycles = 0; done_cnt = 0; hold_cycles = 0; init_seen = 0; timed_out = 1; hold_ctrl = '0;
    obs_cnt.delete(); obs_ad.delete(); obs_hold.delete();
    @(negedge clk_edp_h);
    mul_steps_h = steps;
    mul_start_h = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_edp_h);
      mul_start_h = 0;
      edp_hold_h  = (i >= hold_at && i < hold_at + hold_len);
      mul_abort_h = (i == abort_at);
      mq_35_h     = mq_seq[k];
      #1;
      if (i == 0) init_seen = ar_clr_h && mq_load_h && !arx_shift_h && !mq_shift_h && ad_func_h == 2'b00;
      if (!mul_busy_h) begin timed_out = 0; break; end
      busy_cycles++;
      if (edp_hold_h) begin
        hold_ctrl |= {ar_clr_h, mq_load_h, arx_shift_h, mq_shift_h, mul_done_h, ad_func_h};
        obs_hold.push_back(step_count_h);
      end
      if (arx_shift_h) begin
        obs_cnt.push_back(step_count_h);
        obs_ad.push_back(ad_func_h);
        k++;
      end
      if (mul_done_h) begin
        done_cnt++;
        if (start_in_done) mul_start_h = 1;
      end
    end
    mul_abort_h = 0;
    edp_hold_h  = 0;
    end_cnt = step_count_h;
  endtask

  // Pushes expected step counts and Booth AD codes for an uninterrupted run
  task automatic expect_steps(input int n, input logic [63:0] mq_seq);
    logic prev, b;
    prev = 0;
    exp_cnt.delete(); exp_ad.delete();
    for (int i = 0; i < n; i++) begin
      b = mq_seq[i];
      exp_cnt.push_back(6'(n - i));
      exp_ad.push_back((b && !prev) ? 2'b10 : (!b && prev) ? 2'b01 : 2'b00);
      prev = b;
    end
  endtask

  task automatic test_reset;
    clk_mr_reset_h = 1; mul_start_h = 1; mul_steps_h = 4;
    repeat (3) @(negedge clk_edp_h);
    #1;
    n_cmp++;
    if ({mul_busy_h, mul_done_h, ar_clr_h, mq_load_h, ad_func_h, arx_shift_h, mq_shift_h, step_count_h} !== 14'd0) begin
      n_bad++; $display("FAIL reset_outputs got busy=%b done=%b clr=%b ld=%b ad=%b sh=%b%b cnt=%0d want all 0",
        mul_busy_h, mul_done_h, ar_clr_h, mq_load_h, ad_func_h, arx_shift_h, mq_shift_h, step_count_h);
    end
    mul_start_h = 0; clk_mr_reset_h = 0;
    repeat (2) @(negedge clk_edp_h);
    #1;
    n_cmp++;
    if (mul_busy_h !== 1'b0 || step_count_h !== 6'd0) begin
      n_bad++; $display("FAIL idle_after_reset got busy=%b cnt=%0d want busy=0 cnt=0", mul_busy_h, step_count_h);
    end
  endtask

  task automatic test_basic;
    logic [5:0] e, o;
    expect_steps(4, 64'h0);
    run_op(6'd4, 64'h0, 999, 0, 999, 0);
    n_cmp++;
    if (!init_seen) begin n_bad++; $display("FAIL basic_init got clr=0/ld=0 want ar_clr=mq_load=1"); end
    n_cmp++;
    if (busy_cycles !== 6) begin n_bad++; $display("FAIL basic_busy got %0d want 6", busy_cycles); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    while (exp_cnt.size() != 0) begin
      e = exp_cnt.pop_front();
      o = (obs_cnt.size() != 0) ? obs_cnt.pop_front() : 6'h3F;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic_step_count got %0d want %0d", o, e); end
    end
    n_cmp++;
    if (obs_cnt.size() != 0) begin n_bad++; $display("FAIL basic_extra_steps got %0d want 0", obs_cnt.size()); end
  endtask

  task automatic test_booth;
    logic [63:0] seq;
    logic [1:0] e, o;
    seq = 64'b0011;
    expect_steps(4, seq);
    run_op(6'd4, seq, 999, 0, 999, 0);
    while (exp_ad.size() != 0) begin
      e = exp_ad.pop_front();
      o = (obs_ad.size() != 0) ? obs_ad.pop_front() : 2'bxx;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL booth_ad got %b want %b", o, e); end
    end
    seq = 64'b1010_0110;
    expect_steps(8, seq);
    run_op(6'd8, seq, 999, 0, 999, 0);
    while (exp_ad.size() != 0) begin
      e = exp_ad.pop_front();
      o = (obs_ad.size() != 0) ? obs_ad.pop_front() : 2'bxx;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL booth8_ad got %b want %b", o, e); end
    end
  endtask

  task automatic test_hold;
    logic [5:0] e, o;
    expect_steps(3, 64'b101);
    run_op(6'd3, 64'b101, 2, 2, 999, 0);
    n_cmp++;
    if (busy_cycles !== 7) begin n_bad++; $display("FAIL hold_busy got %0d want 7", busy_cycles); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL hold_done got %0d want 1", done_cnt); end
    n_cmp++;
    if (hold_ctrl !== 7'd0) begin n_bad++; $display("FAIL hold_ctrl got %b want 0000000", hold_ctrl); end
    n_cmp++;
    if (obs_hold.size() !== 2) begin n_bad++; $display("FAIL hold_len got %0d want 2", obs_hold.size()); end
    while (obs_hold.size() != 0) begin
      o = obs_hold.pop_front();
      n_cmp++;
      if (o !== 6'd2) begin n_bad++; $display("FAIL hold_frozen_cnt got %0d want 2", o); end
    end
    while (exp_cnt.size() != 0) begin
      e = exp_cnt.pop_front();
      o = (obs_cnt.size() != 0) ? obs_cnt.pop_front() : 6'h3F;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL hold_step_count got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_abort;
    run_op(6'd36, 64'hFFFF, 999, 0, 3, 0);
    n_cmp++;
    if (busy_cycles !== 4) begin n_bad++; $display("FAIL abort_busy got %0d want 4", busy_cycles); end
    n_cmp++;
    if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done got %0d want 0", done_cnt); end
    n_cmp++;
    if (end_cnt !== 6'd0) begin n_bad++; $display("FAIL abort_cnt got %0d want 0", end_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [5:0] e, o;
    @(negedge clk_edp_h);
    mul_steps_h = 6'd10; mul_start_h = 1; mq_35_h = 1;
    repeat (4) @(negedge clk_edp_h);
    mul_start_h = 0;
    clk_mr_reset_h = 1;
    @(negedge clk_edp_h);
    #1;
    n_cmp++;
    if ({mul_busy_h, arx_shift_h, mq_shift_h, ad_func_h, step_count_h} !== 11'd0) begin
      n_bad++; $display("FAIL reset_mid got busy=%b sh=%b ad=%b cnt=%0d want 0", mul_busy_h, arx_shift_h, ad_func_h, step_count_h);
    end
    clk_mr_reset_h = 0;
    expect_steps(1, 64'h0);
    run_op(6'd1, 64'h0, 999, 0, 999, 0);
    e = {4'd0, exp_ad.pop_front()};
    o = (obs_ad.size() != 0) ? {4'd0, obs_ad.pop_front()} : 6'h3F;
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_prev_ad got %0d want %0d", o, e); end
  endtask

  task automatic test_clamp;
    logic [5:0] e, o;
    for (int t = 0; t < 2; t++) begin
      expect_steps(36, 64'h0);
      run_op((t == 0) ? 6'd0 : 6'd63, 64'h0, 999, 0, 999, t == 1);
      n_cmp++;
      if (obs_cnt.size() !== 36) begin n_bad++; $display("FAIL clamp_steps t=%0d got %0d want 36", t, obs_cnt.size()); end
      n_cmp++;
      if (busy_cycles !== 38) begin n_bad++; $display("FAIL clamp_busy t=%0d got %0d want 38", t, busy_cycles); end
      e = exp_cnt.pop_front();
      o = (obs_cnt.size() != 0) ? obs_cnt.pop_front() : 6'h3F;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL clamp_first_cnt t=%0d got %0d want %0d", t, o, e); end
    end
    mul_start_h = 0;
    @(negedge clk_edp_h);
    #1;
    n_cmp++;
    if (mul_busy_h !== 1'b0 || ar_clr_h !== 1'b0) begin
      n_bad++; $display("FAIL start_in_done got busy=%b clr=%b want 0 0", mul_busy_h, ar_clr_h);
    end
  endtask

`ifdef EDP_MUL_STATS_EN
  task automatic test_stats;
    clk_mr_reset_h = 1;
    @(negedge clk_edp_h);
    clk_mr_reset_h = 0;
    for (int r = 0; r < 3; r++) run_op(6'd2, 64'h0, 999, 0, 999, 0);
    run_op(6'd5, 64'h0, 999, 0, 2, 0);
    n_cmp++;
    if (mul_count_h !== 16'd3) begin n_bad++; $display("FAIL stats_count got %0d want 3", mul_count_h); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_booth;
    test_hold;
    test_abort;
    test_reset_mid;
    test_clamp;
`ifdef EDP_MUL_STATS_EN
    test_stats;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
